// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep controller slice.
package dds_pkg;

  localparam int unsigned DDS_DEPTH_W = 16;
  localparam int unsigned DDS_DWELL_W = 16;

  typedef enum logic [1:0] {
    SINGLE_UP  = 2'd0,
    SINGLE_TRI = 2'd1,
    CONT_SAW   = 2'd2,
    CONT_TRI   = 2'd3
  } sweep_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; expire marks the last cycle of the current step.
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int unsigned W = DDS_DWELL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] dwell,
  output logic         expire
);

  logic [W-1:0] cnt;

  // A dwell of 0 loads the same value as a dwell of 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (dwell == '0) ? '0 : dwell - W'(1);
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Stepped frequency sweep generator driving the dds fword/pword inputs.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned DEPTH_BITWIDTH = DDS_DEPTH_W,
  parameter int unsigned DWELL_BITWIDTH = DDS_DWELL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                mode,
  input  logic [DEPTH_BITWIDTH-1:0] f_start,
  input  logic [DEPTH_BITWIDTH-1:0] f_stop,
  input  logic [DEPTH_BITWIDTH-1:0] f_step,
  input  logic [DWELL_BITWIDTH-1:0] dwell,
  input  logic [DEPTH_BITWIDTH-1:0] phase,
  output logic [DEPTH_BITWIDTH-1:0] fword,
  output logic [DEPTH_BITWIDTH-1:0] pword,
  output logic                      busy,
  output logic                      done,
  output logic                      wrap
);

  localparam int unsigned XW = DEPTH_BITWIDTH + 1;

  sweep_state_e              state;
  sweep_mode_e               mode_q;
  logic [DEPTH_BITWIDTH-1:0] f_start_q, f_stop_q, f_step_q;
  logic [DWELL_BITWIDTH-1:0] dwell_q;

  logic                      expire;
  logic                      accept_c, step_c, degenerate_c, at_top_c, at_bot_c;
  logic [XW-1:0]             up_sum_c, dn_thr_c;
  logic [DEPTH_BITWIDTH-1:0] up_next_c, dn_next_c;

  assign accept_c = (state == IDLE) && start && !abort;
  assign step_c   = (state != IDLE) && expire && !abort;

  dds_dwell_timer #(.W(DWELL_BITWIDTH)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_c || step_c),
    .count  (state != IDLE),
    .dwell  ((state == IDLE) ? dwell : dwell_q),
    .expire (expire)
  );

  // Step arithmetic carries one extra bit so clamping also catches overflow.
  assign up_sum_c  = XW'(fword) + XW'(f_step_q);
  assign up_next_c = (up_sum_c >= XW'(f_stop_q)) ? f_stop_q : up_sum_c[DEPTH_BITWIDTH-1:0];
  assign dn_thr_c  = XW'(f_start_q) + XW'(f_step_q);
  assign dn_next_c = (XW'(fword) < dn_thr_c) ? f_start_q : fword - f_step_q;

  assign degenerate_c = (f_step_q == '0) || (f_start_q >= f_stop_q);
  assign at_top_c     = degenerate_c || (fword == f_stop_q);
  assign at_bot_c     = (fword == f_start_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= SINGLE_UP;
      f_start_q <= '0;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      dwell_q   <= '0;
      fword     <= '0;
      pword     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mode_q    <= sweep_mode_e'(mode);
              f_start_q <= f_start;
              f_stop_q  <= f_stop;
              f_step_q  <= f_step;
              dwell_q   <= dwell;
              fword     <= f_start;
              pword     <= phase;
              busy      <= 1'b1;
              state     <= UP;
            end
          end
          UP: begin
            if (expire) begin
              if (at_top_c) begin
                wrap <= 1'b1;
                if ((mode_q == SINGLE_UP) || ((mode_q == SINGLE_TRI) && degenerate_c)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else if ((mode_q == CONT_SAW) || degenerate_c) begin
                  fword <= f_start_q;
                end else begin
                  state <= DOWN;
                  fword <= dn_next_c;
                end
              end else begin
                fword <= up_next_c;
              end
            end
          end
          DOWN: begin
            if (expire) begin
              if (at_bot_c) begin
                wrap <= 1'b1;
                if (mode_q == CONT_TRI) begin
                  state <= UP;
                  fword <= up_next_c;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                fword <= dn_next_c;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized and directed checks of dds_sweep_ctrl against a value-list sweep model.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] f_start = '0, f_stop = '0, f_step = '0, dwell = '0, phase = '0;
  logic [15:0] fword, pword;
  logic        busy, done, wrap;

  int total = 0;
  int bad = 0;
  int last_f = 0;
  int last_p = 0;

  dds_sweep_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .f_start (f_start),
    .f_stop  (f_stop),
    .f_step  (f_step),
    .dwell   (dwell),
    .phase   (phase),
    .fword   (fword),
    .pword   (pword),
    .busy    (busy),
    .done    (done),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    mode    = 2'($urandom_range(0, 3));
    f_start = 16'($urandom);
    f_stop  = 16'($urandom);
    f_step  = 16'($urandom);
    dwell   = 16'($urandom_range(0, 7));
    phase   = 16'($urandom);
  endtask

  // Model: list the tuning values of the sweep, then expand each by the dwell.
  task automatic run_sweep(input int md, input int fs, input int fp, input int st,
                           input int dw, input int ph, input int abort_at);
    int vals[$];
    bit term[$];
    int ef[$];
    bit eb[$], ed[$], ew[$];
    int d, n, v, ab;
    bit degen, single;

    d      = (dw == 0) ? 1 : dw;
    single = (md == 0) || (md == 1);
    degen  = (st == 0) || (fs >= fp);

    v = fs;
    vals.push_back(fs);
    term.push_back(degen);
    if (degen) begin
      if (!single) while (vals.size() < 80) begin vals.push_back(fs); term.push_back(1'b1); end
    end else begin
      while (vals.size() < 80) begin
        while (v != fp && vals.size() < 80) begin
          v = (v + st >= fp) ? fp : v + st;
          vals.push_back(v);
          term.push_back(v == fp);
        end
        if (md == 0) break;
        if (md == 2) begin
          v = fs;
          vals.push_back(fs);
          term.push_back(1'b0);
          continue;
        end
        while (v != fs && vals.size() < 80) begin
          v = (v < fs + st) ? fs : v - st;
          vals.push_back(v);
          term.push_back(v == fs);
        end
        if (md == 1) break;
      end
    end

    ef.push_back(0); eb.push_back(0); ed.push_back(0); ew.push_back(0);
    foreach (vals[i]) begin
      for (int k = 0; k < d; k++) begin
        ef.push_back(vals[i]);
        eb.push_back(1'b1);
        ed.push_back(1'b0);
        ew.push_back((k == 0) && (i > 0) && term[i-1]);
      end
    end
    if (single) begin
      ef.push_back(vals[vals.size()-1]); eb.push_back(1'b0); ed.push_back(1'b1); ew.push_back(1'b1);
      for (int k = 0; k < 3; k++) begin
        ef.push_back(vals[vals.size()-1]); eb.push_back(1'b0); ed.push_back(1'b0); ew.push_back(1'b0);
      end
      n = ef.size() - 1;
    end else begin
      n = 60;
    end

    ab = abort_at;
    if (!single && ab == 0) ab = n - 3;
    if (ab > 0 && ab < n) begin
      for (int c = ab + 1; c <= n; c++) begin
        ef[c] = ef[ab]; eb[c] = 1'b0; ed[c] = 1'b0; ew[c] = 1'b0;
      end
    end else begin
      ab = 0;
    end

    mode    = 2'(md);
    f_start = 16'(fs);
    f_stop  = 16'(fp);
    f_step  = 16'(st);
    dwell   = 16'(dw);
    phase   = 16'(ph);
    abort   = 1'b0;
    start   = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      check_eq($sformatf("fword m%0d c%0d", md, c), int'(fword), ef[c]);
      check_eq($sformatf("pword m%0d c%0d", md, c), int'(pword), ph);
      check_eq($sformatf("busy m%0d c%0d", md, c), int'(busy), int'(eb[c]));
      check_eq($sformatf("done m%0d c%0d", md, c), int'(done), int'(ed[c]));
      check_eq($sformatf("wrap m%0d c%0d", md, c), int'(wrap), int'(ew[c]));
      abort = (c == ab);
      start = eb[c] && ($urandom_range(0, 3) == 0);
      if (c < n) scramble_inputs();
    end
    start  = 1'b0;
    abort  = 1'b0;
    last_f = ef[n];
    last_p = ph;
  endtask

  initial begin
    int fs, fp, st;

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset fword", int'(fword), 0);
    check_eq("reset pword", int'(pword), 0);
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset done", int'(done), 0);
    check_eq("reset wrap", int'(wrap), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_sweep(0, 100, 400, 100, 3, 16'h1234, 0);
    run_sweep(0, 0, 250, 100, 1, 7, 0);
    run_sweep(0, 16'hFF00, 16'hFFFF, 16'h80, 2, 0, 0);
    run_sweep(1, 0, 300, 100, 2, 5, 0);
    run_sweep(3, 0, 300, 100, 2, 9, 0);
    run_sweep(0, 100, 400, 100, 3, 16'h55, 5);
    run_sweep(2, 500, 900, 0, 4, 3, 0);
    run_sweep(1, 800, 200, 50, 0, 1, 0);

    // start and abort together while idle must not launch a sweep
    mode = 2'd2; f_start = 16'd10; f_stop = 16'd90; f_step = 16'd10; dwell = 16'd1; phase = 16'd77;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check_eq("start+abort busy", int'(busy), 0);
    check_eq("start+abort fword", int'(fword), last_f);
    check_eq("start+abort pword", int'(pword), last_p);
    @(posedge clk); #1;
    check_eq("start+abort busy later", int'(busy), 0);

    for (int r = 0; r < 25; r++) begin
      fs = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0 || fs == 65535) fp = fs - int'($urandom_range(0, 3));
      else fp = fs + int'($urandom_range(1, 65535 - fs));
      if (fp < 0) fp = 0;
      if ($urandom_range(0, 7) == 0) st = 0;
      else st = ((fp > fs) ? (fp - fs) / int'($urandom_range(1, 10)) : 1) + int'($urandom_range(0, 3));
      st = st & 16'hFFFF;
      run_sweep(int'($urandom_range(0, 3)), fs, fp, st, int'($urandom_range(0, 4)),
                int'($urandom_range(0, 65535)),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : 0);
    end

    // reset in the middle of a continuous sweep clears outputs without a clock edge
    mode = 2'd3; f_start = 16'd1000; f_stop = 16'd2000; f_step = 16'd300; dwell = 16'd2; phase = 16'hABCD;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("midreset fword", int'(fword), 0);
    check_eq("midreset pword", int'(pword), 0);
    check_eq("midreset busy", int'(busy), 0);
    check_eq("midreset done", int'(done), 0);
    check_eq("midreset wrap", int'(wrap), 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post reset busy", int'(busy), 0);
    check_eq("post reset done", int'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Upstream frequency-sweep controller for the `dds` core. Drives the DDS `fword`/`pword` inputs with a stepped ramp between two programmed tuning words, holding each step for a programmable number of clocks. Supports single and continuous sawtooth and triangle sweeps with a start/busy/done handshake. Outputs are registered and connect directly to the `dds` `fword`/`pword` ports.

## Interface
- `DEPTH_BITWIDTH`, 16, width of tuning/phase words; matches the `dds` depth.
- `DWELL_BITWIDTH`, 16, width of the dwell count.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  single-cycle request; sampled only when `busy`=0.
- `abort`  in  1  stops the sweep; highest priority.
- `mode`  in  2  0 = single up, 1 = single triangle, 2 = continuous sawtooth, 3 = continuous triangle.
- `f_start`  in  DEPTH_BITWIDTH  lower tuning word.
- `f_stop`  in  DEPTH_BITWIDTH  upper tuning word.
- `f_step`  in  DEPTH_BITWIDTH  step size.
- `dwell`  in  DWELL_BITWIDTH  cycles held per step; 0 is treated as 1.
- `phase`  in  DEPTH_BITWIDTH  phase offset.
- `fword`  out  DEPTH_BITWIDTH  to `dds.fword`.
- `pword`  out  DEPTH_BITWIDTH  to `dds.pword`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a single sweep completes.
- `wrap`  out  1  one-cycle pulse at the end of each terminal-frequency dwell.

## Operation
- Reset values: `fword`=0, `pword`=0, `busy`=0, `done`=0, `wrap`=0, state IDLE.
- **Start:** `start`=1 in IDLE latches `mode`, `f_start`, `f_stop`, `f_step`, `dwell` and `phase`. Input changes while `busy`=1 are ignored. `start` while busy is ignored.
- **States:** IDLE, UP, DOWN.
  - IDLE→UP on start.
  - UP at `f_stop` dwell end: mode 0 → IDLE; mode 2 → UP restarting at `f_start`; modes 1/3 → DOWN.
  - DOWN at `f_start` dwell end: mode 1 → IDLE; mode 3 → UP.
- **Up step:** compute `fword + f_step` at DEPTH_BITWIDTH+1 bits. If the result is ≥ `f_stop`, the next value is `f_stop` (clamp, which also covers overflow).
- **Down step:** if `fword` < `f_start + f_step` (computed at +1 bits), the next value is `f_start`.
- **Terminal repeats:** terminal values are not repeated at a direction change. The triangle goes …, `f_stop`, `f_stop − step`, … and …, `f_start`, `f_start + step`, ….
- **Degenerate config:** if `f_step`=0 or `f_start` ≥ `f_stop`, `fword` stays at `f_start` and each pass lasts one dwell period. Modes 0/1 complete after one dwell. Modes 2/3 pulse `wrap` every dwell period until abort.
- **wrap:** pulses at the end of each terminal dwell, including the final one where it coincides with `done`.
- **Abort:** takes effect in any state. Next cycle: IDLE, `busy`=0. `fword`/`pword` hold their values, and `done`/`wrap` are not asserted. If `abort` and `start` arrive in the same IDLE cycle, abort wins.
- **Idle hold:** after `done` or abort, `fword`/`pword` hold the last values until the next start.

## Timing
- `start` sampled at edge N → in cycle N+1: `busy`=1, `fword`=`f_start`, `pword`=latched `phase`.
- Each value is held for exactly max(`dwell`,1) cycles; the step change is registered, so there are no bubble cycles.
- Single sweep completion: in the cycle after the last dwell cycle, `done`=1 and `wrap`=1 for one cycle and `busy`=0.
- Continuous modes: `wrap` pulses in the first cycle of the next value.
- Reset asserted mid-sweep: all outputs go immediately to their reset values with no `done`.

## Structure
- `dds_pkg`: `sweep_mode_e` (SINGLE_UP, SINGLE_TRI, CONT_SAW, CONT_TRI) and `sweep_state_e` (IDLE, UP, DOWN).
- Sub-module `dds_dwell_timer`: loadable down-counter with `load`, `count`, `expire` ports. It reloads on every step and treats 0 as 1.

## Test plan
- Mode 0, `f_start`=100, `f_stop`=400, `f_step`=100, `dwell`=3, start at cycle 0 → `fword` is 100 in cycles 1–3, 200 in 4–6, 300 in 7–9, 400 in 10–12. Cycle 13: `done`=`wrap`=1, `busy`=0, `fword`=400.
- Clamp, mode 0: 0/250/100, `dwell`=1 → 0, 100, 200, 250, then `done`.
- Overflow clamp: 0xFF00/0xFFFF/0x80 → 0xFF00, 0xFF80, 0xFFFF; no wrap to a low value.
- Mode 1: 0/300/100, `dwell`=2 → 0, 100, 200, 300, 200, 100, 0 (2 cycles each); `wrap` after 300 and at `done`. Mode 3: the same sequence repeats with no repeated 0.
- Abort at cycle 5 of the first test → `busy`=0 at cycle 6, `fword` frozen at 200, no `done`. A simultaneous start+abort in IDLE stays IDLE.
- Degenerate case: `f_step`=0, mode 2, `dwell`=4 → `fword`=`f_start` constant, `wrap` every 4 cycles. Reset asserted mid-sweep → all outputs 0 asynchronously.
